keypad_scan: RTL and testbench

//  Input-side counterpart of the multiplexed 7-segment display path: scans a 4x4 matrix keypad.

---
 rtl/keypad_scan.sv | 208 ++++++++++++++++++++
 tb/tb_keypad_scan.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// keypad_scan
//   Scans a 4x4 matrix keypad. One column is driven low at a time. The
//   active-low row lines are synchronised and then sampled at the end of each
//   column step. Whole scan frames are debounced, and one clean key code is
//   reported per press. Multi-key frames are treated as "no key" so that
//   ghost patterns never reach the counter/clock-setting logic downstream.
//
// Ports
//   clk          in   1  system clock
//   rst          in   1  asynchronous, active-high reset
//   i_row        in   4  keypad rows, active-low, asynchronous to clk
//   o_col        out  4  column drive, one-cold, registered
//   o_key        out  4  last accepted key code (row*4 + col)
//   o_key_valid  out  1  one-cycle pulse when a new press is accepted
//   o_key_held   out  1  high while the accepted key remains pressed
// ---------------------------------------------------------------------------
module keypad_scan #(
    parameter int SCAN_DIV = 50000,
    parameter int DEB_CNT  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i_row,
    output logic [3:0] o_col,
    output logic [3:0] o_key,
    output logic       o_key_valid,
    output logic       o_key_held
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEB_CNT + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESS   = 2'd1;
    localparam logic [1:0] ST_HELD    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    logic [3:0]       rowMeta_q, rowSync_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       colIdx_q;
    logic [3:0]       col_q;
    logic [1:0]       accCnt_q;
    logic [3:0]       accCode_q;
    logic [1:0]       state_q, state_d;
    logic [3:0]       cand_q, cand_d;
    logic [DEB_W-1:0] deb_q, deb_d;
    logic [3:0]       key_q, key_d;
    logic             valid_q, valid_d;
    logic             held_q, held_d;

    logic             tick, frameEnd;
    logic [3:0]       colHits;
    logic [2:0]       colCount;
    logic [1:0]       lowRow;
    logic [2:0]       sumCnt;
    logic [1:0]       frameCnt;
    logic [3:0]       frameCode;
    logic             frameOne;
    logic [DEB_W-1:0] debInc;

    // Two-flop synchroniser; idle rows read as released (all ones).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rowMeta_q <= 4'b1111;
            rowSync_q <= 4'b1111;
        end else begin
            rowMeta_q <= i_row;
            rowSync_q <= rowMeta_q;
        end
    end

    assign tick     = (cnt_q == CNT_W'(SCAN_DIV - 1));
    assign frameEnd = tick && (colIdx_q == 2'd3);

    // Column step divider and column walker. Sampling happens on the last
    // cycle of a step, so the rows have settled through the synchroniser.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            colIdx_q <= 2'd0;
            col_q    <= 4'b1110;
        end else if (tick) begin
            cnt_q    <= '0;
            colIdx_q <= colIdx_q + 2'd1;
            col_q    <= ~(4'b0001 << (colIdx_q + 2'd1));
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Presses seen in the current column, merged with the frame so far.
    // The first code wins because columns are visited in ascending order
    // and the lowest pressed row within the column is taken.
    always_comb begin
        colHits  = ~rowSync_q;
        colCount = {2'b00, colHits[0]} + {2'b00, colHits[1]}
                 + {2'b00, colHits[2]} + {2'b00, colHits[3]};
        lowRow   = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (colHits[r]) begin
                lowRow = 2'(r);
            end
        end
        sumCnt    = {1'b0, accCnt_q} + colCount;
        frameCnt  = (sumCnt >= 3'd2) ? 2'd2 : sumCnt[1:0];
        frameCode = (accCnt_q == 2'd0) ? {lowRow, colIdx_q} : accCode_q;
        frameOne  = (frameCnt == 2'd1);
    end

    // Frame accumulators; cleared on the frame-end tick so the next frame
    // starts empty at column 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            accCnt_q  <= 2'd0;
            accCode_q <= 4'd0;
        end else if (frameEnd) begin
            accCnt_q  <= 2'd0;
            accCode_q <= 4'd0;
        end else if (tick) begin
            accCnt_q  <= frameCnt;
            accCode_q <= frameCode;
        end
    end

    assign debInc = deb_q + DEB_W'(1);

    // Debounce FSM, advanced only once per frame. deb counts frames that
    // agree with the move being debounced (toward HELD or toward IDLE).
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        deb_d   = deb_q;
        key_d   = key_q;
        valid_d = 1'b0;
        held_d  = held_q;
        if (frameEnd) begin
            case (state_q)
                ST_IDLE: begin
                    if (frameOne) begin
                        cand_d  = frameCode;
                        deb_d   = DEB_W'(1);
                        state_d = ST_PRESS;
                    end
                end
                ST_PRESS: begin
                    if (frameOne && frameCode == cand_q) begin
                        deb_d = debInc;
                        if (debInc == DEB_W'(DEB_CNT)) begin
                            state_d = ST_HELD;
                            key_d   = cand_q;
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                        end
                    end else if (frameOne) begin
                        cand_d = frameCode;
                        deb_d  = DEB_W'(1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_HELD: begin
                    if (!(frameOne && frameCode == key_q)) begin
                        state_d = ST_RELEASE;
                        deb_d   = DEB_W'(1);
                    end
                end
                default: begin
                    if (frameOne && frameCode == key_q) begin
                        state_d = ST_HELD;
                    end else begin
                        deb_d = debInc;
                        if (debInc == DEB_W'(DEB_CNT)) begin
                            state_d = ST_IDLE;
                            held_d  = 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    // FSM and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cand_q  <= 4'd0;
            deb_q   <= '0;
            key_q   <= 4'd0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            deb_q   <= deb_d;
            key_q   <= key_d;
            valid_q <= valid_d;
            held_q  <= held_d;
        end
    end

    assign o_col       = col_q;
    assign o_key       = key_q;
    assign o_key_valid = valid_q;
    assign o_key_held  = held_q;

endmodule

// File: tb/tb_keypad_scan.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_keypad_scan
//   Drives keypad_scan with a matrix keypad model and compares the outputs
//   against a frame-level model of the debounce rules. The bench parameters
//   give a 16-cycle frame; key patterns change only at frame boundaries.
// ---------------------------------------------------------------------------
module tb_keypad_scan;

    localparam int SD  = 4;
    localparam int DEB = 3;

    logic        clk;
    logic        rst;
    logic [3:0]  iRow;
    logic [3:0]  oCol;
    logic [3:0]  oKey;
    logic        oKeyValid;
    logic        oKeyHeld;
    logic [15:0] pressed;

    int errors;
    int checks;

    // Frame-level model: run of identical single-key frames while nothing
    // is held, and run of frames without the held key while something is.
    int       runLen;
    logic [3:0] runKey;
    bit       mHeld;
    logic [3:0] mKey;
    int       awayLen;

    keypad_scan #(.SCAN_DIV(SD), .DEB_CNT(DEB)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_row       (iRow),
        .o_col       (oCol),
        .o_key       (oKey),
        .o_key_valid (oKeyValid),
        .o_key_held  (oKeyHeld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad: a row reads low when a pressed key sits on a driven column.
    always_comb begin
        iRow = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!oCol[c] && pressed[r*4 + c]) begin
                    iRow[r] = 1'b0;
                end
            end
        end
    end

    function automatic void modelReset();
        runLen  = 0;
        runKey  = 4'd0;
        mHeld   = 1'b0;
        mKey    = 4'd0;
        awayLen = 0;
    endfunction

    // Returns 1 when this frame should produce an acceptance pulse.
    function automatic bit modelFrame(input logic [15:0] mask);
        int   n;
        logic [3:0] code;
        bit   one;
        n    = 0;
        code = 4'd0;
        for (int k = 15; k >= 0; k--) begin
            if (mask[k]) begin
                n++;
                code = 4'(k);
            end
        end
        one = (n == 1);
        if (!mHeld) begin
            if (one && runLen > 0 && code == runKey) begin
                runLen++;
            end else if (one) begin
                runKey = code;
                runLen = 1;
            end else begin
                runLen = 0;
            end
            if (runLen == DEB) begin
                mHeld  = 1'b1;
                mKey   = runKey;
                runLen = 0;
                return 1'b1;
            end
        end else begin
            if (one && code == mKey) begin
                awayLen = 0;
            end else begin
                awayLen++;
            end
            if (awayLen == DEB) begin
                mHeld   = 1'b0;
                awayLen = 0;
                runLen  = 0;
            end
        end
        return 1'b0;
    endfunction

    // Applies one frame of key pattern and records what the DUT showed.
    task automatic runFrame(input logic [15:0] mask, output logic [15:0] vTrace,
                            output logic [63:0] cTrace, output logic [3:0] keyEnd,
                            output logic heldEnd);
        pressed = mask;
        for (int i = 0; i < 4*SD; i++) begin
            @(posedge clk);
            #1;
            vTrace[i]        = oKeyValid;
            cTrace[i*4 +: 4] = oCol;
        end
        keyEnd  = oKey;
        heldEnd = oKeyHeld;
    endtask

    task automatic applyReset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        modelReset();
    endtask

    task automatic test_reset();
        logic [15:0] vt;
        logic [63:0] ct, expCt;
        logic [3:0]  k, e;
        logic        h;
        pressed = 16'h0000;
        rst = 1'b0;
        #3 rst = 1'b1;
        #1;
        checks++;
        if (oCol !== 4'b1110) begin
            errors++;
            $display("[TB] FAIL reset_col: got %b want 1110", oCol);
        end
        checks++;
        if (oKey !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_key: got %0d want 0", oKey);
        end
        checks++;
        if (oKeyValid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_valid: got %b want 0", oKeyValid);
        end
        checks++;
        if (oKeyHeld !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_held: got %b want 0", oKeyHeld);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        modelReset();
        for (int f = 0; f < 2; f++) begin
            runFrame(16'h0000, vt, ct, k, h);
            void'(modelFrame(16'h0000));
            for (int i = 0; i < 4*SD; i++) begin
                e = 4'b0001 << (((i + 1) / SD) % 4);
                expCt[i*4 +: 4] = ~e;
            end
            checks++;
            if (ct !== expCt) begin
                errors++;
                $display("[TB] FAIL col_walk frame %0d: got %h want %h", f, ct, expCt);
            end
            checks++;
            if (vt !== 16'h0000) begin
                errors++;
                $display("[TB] FAIL idle_valid frame %0d: got %h want 0000", f, vt);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [15:0] vt, m;
        logic [63:0] ct;
        logic [3:0]  k;
        logic        h;
        bit          exp;
        for (int f = 0; f < 8; f++) begin
            m = (f < 4) ? 16'h0040 : 16'h0000;
            runFrame(m, vt, ct, k, h);
            exp = modelFrame(m);
            checks++;
            if (vt !== (exp ? 16'h8000 : 16'h0000)) begin
                errors++;
                $display("[TB] FAIL press6_valid frame %0d: got %h want %h", f, vt, exp ? 16'h8000 : 16'h0000);
            end
            checks++;
            if ({k, h} !== {mKey, mHeld}) begin
                errors++;
                $display("[TB] FAIL press6_key_held frame %0d: got %0d/%b want %0d/%b", f, k, h, mKey, mHeld);
            end
        end
    endtask

    task automatic test_bounce();
        logic [15:0] vt, m;
        logic [63:0] ct;
        logic [3:0]  k;
        logic        h;
        bit          exp;
        for (int f = 0; f < 12; f++) begin
            if (f < 4) m = (f % 2 == 0) ? 16'h0200 : 16'h0000;
            else if (f < 9) m = 16'h0200;
            else m = 16'h0000;
            runFrame(m, vt, ct, k, h);
            exp = modelFrame(m);
            checks++;
            if (vt !== (exp ? 16'h8000 : 16'h0000)) begin
                errors++;
                $display("[TB] FAIL bounce9_valid frame %0d: got %h want %h", f, vt, exp ? 16'h8000 : 16'h0000);
            end
            checks++;
            if ({k, h} !== {mKey, mHeld}) begin
                errors++;
                $display("[TB] FAIL bounce9_key_held frame %0d: got %0d/%b want %0d/%b", f, k, h, mKey, mHeld);
            end
        end
    endtask

    task automatic test_ghost();
        logic [15:0] vt, m;
        logic [63:0] ct;
        logic [3:0]  k;
        logic        h;
        bit          exp;
        m = 16'h0420;
        for (int f = 0; f < 10; f++) begin
            runFrame(m, vt, ct, k, h);
            exp = modelFrame(m);
            checks++;
            if (vt !== (exp ? 16'h8000 : 16'h0000)) begin
                errors++;
                $display("[TB] FAIL ghost_valid frame %0d: got %h want %h", f, vt, exp ? 16'h8000 : 16'h0000);
            end
            checks++;
            if ({k, h} !== {mKey, mHeld}) begin
                errors++;
                $display("[TB] FAIL ghost_key_held frame %0d: got %0d/%b want %0d/%b", f, k, h, mKey, mHeld);
            end
        end
    endtask

    task automatic test_switch();
        logic [15:0] vt, m;
        logic [63:0] ct;
        logic [3:0]  k;
        logic        h;
        bit          exp;
        for (int f = 0; f < 14; f++) begin
            if (f < 3) m = 16'h0001;
            else if (f < 11) m = 16'h8000;
            else m = 16'h0000;
            runFrame(m, vt, ct, k, h);
            exp = modelFrame(m);
            checks++;
            if (vt !== (exp ? 16'h8000 : 16'h0000)) begin
                errors++;
                $display("[TB] FAIL switch_valid frame %0d: got %h want %h", f, vt, exp ? 16'h8000 : 16'h0000);
            end
            checks++;
            if ({k, h} !== {mKey, mHeld}) begin
                errors++;
                $display("[TB] FAIL switch_key_held frame %0d: got %0d/%b want %0d/%b", f, k, h, mKey, mHeld);
            end
        end
    endtask

    task automatic test_reset_mid_press();
        logic [15:0] vt, m;
        logic [63:0] ct;
        logic [3:0]  k;
        logic        h;
        bit          exp;
        for (int f = 0; f < 2; f++) begin
            runFrame(16'h0008, vt, ct, k, h);
            void'(modelFrame(16'h0008));
            checks++;
            if (vt !== 16'h0000) begin
                errors++;
                $display("[TB] FAIL pre_reset_valid frame %0d: got %h want 0000", f, vt);
            end
        end
        repeat (6) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({oCol, oKey, oKeyValid, oKeyHeld} !== {4'b1110, 4'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got col=%b key=%0d v=%b h=%b want col=1110 key=0 v=0 h=0",
                     oCol, oKey, oKeyValid, oKeyHeld);
        end
        pressed = 16'h0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        modelReset();
        for (int f = 0; f < 5; f++) begin
            m = (f == 0) ? 16'h0000 : 16'h0008;
            runFrame(m, vt, ct, k, h);
            exp = modelFrame(m);
            checks++;
            if (vt !== (exp ? 16'h8000 : 16'h0000)) begin
                errors++;
                $display("[TB] FAIL postreset_valid frame %0d: got %h want %h", f, vt, exp ? 16'h8000 : 16'h0000);
            end
            checks++;
            if ({k, h} !== {mKey, mHeld}) begin
                errors++;
                $display("[TB] FAIL postreset_key_held frame %0d: got %0d/%b want %0d/%b", f, k, h, mKey, mHeld);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] vt, m;
        logic [63:0] ct;
        logic [3:0]  k, curKey, other;
        logic        h;
        bit          exp;
        int          sel;
        curKey = 4'($urandom_range(0, 15));
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 5) == 0) curKey = 4'($urandom_range(0, 15));
            sel   = $urandom_range(0, 5);
            other = curKey + 4'($urandom_range(1, 15));
            if (sel <= 1) m = 16'h0000;
            else if (sel <= 4) m = 16'h0001 << curKey;
            else m = (16'h0001 << curKey) | (16'h0001 << other);
            runFrame(m, vt, ct, k, h);
            exp = modelFrame(m);
            checks++;
            if (vt !== (exp ? 16'h8000 : 16'h0000)) begin
                errors++;
                $display("[TB] FAIL random_valid frame %0d mask %h: got %h want %h", f, m, vt, exp ? 16'h8000 : 16'h0000);
            end
            checks++;
            if ({k, h} !== {mKey, mHeld}) begin
                errors++;
                $display("[TB] FAIL random_key_held frame %0d mask %h: got %0d/%b want %0d/%b", f, m, k, h, mKey, mHeld);
            end
        end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        rst     = 1'b0;
        pressed = 16'h0000;
        modelReset();
        test_reset();
        test_clean_press();
        test_bounce();
        test_ghost();
        test_switch();
        test_reset_mid_press();
        applyReset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
